// File: rtl/nfu_pkg.sv
// Shared definitions for the NFU issue path: FSM state encoding and pipeline/credit defaults.
package nfu_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } nfu_state_e;

   localparam int NFU_MULT_LAT = 3;
   localparam int NFU_CREDITS  = 8;

   // Bits needed to hold the values 0..max_val inclusive.
   function automatic int nfu_cnt_w(input int max_val);
      return $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/nfu_valid_pipe.sv
// Valid-bit shift register tracking buffer-read and multiplier latency; every stage is exposed.
module nfu_valid_pipe #(
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             din_i,
   output logic [DEPTH-1:0] taps_o
);

   logic [DEPTH-1:0] taps_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         taps_q <= '0;
      end else begin
         taps_q <= {taps_q[DEPTH-2:0], din_i};
      end
   end

   assign taps_o = taps_q;

endmodule

// File: rtl/nfu1_issue_ctrl.sv
// NFU-1 tile issue controller: credit-gated NBin/SB reads with valid alignment to NFU-1/NFU-2.
// Optional stall-cycle counter enabled by defining NFU1_PERF_CNT_EN.
module nfu1_issue_ctrl
   import nfu_pkg::*;
#(
   parameter int BIT_WIDTH = 16,
   parameter int Tn        = 16,
   parameter int MULT_LAT  = NFU_MULT_LAT,
   parameter int CREDITS   = NFU_CREDITS,
   parameter int CNT_W     = 16,
   parameter int ADDR_W    = 10
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_start,
   input  logic [CNT_W-1:0]  i_num_tiles,
   input  logic [ADDR_W-1:0] i_nbin_base,
   input  logic [ADDR_W-1:0] i_sb_base,
   output logic              o_nbin_rd_en,
   output logic [ADDR_W-1:0] o_nbin_addr,
   output logic              o_sb_rd_en,
   output logic [ADDR_W-1:0] o_sb_addr,
   output logic              o_nfu1_valid,
   output logic              o_nfu2_valid,
   input  logic              i_credit_ret,
   output logic              o_busy,
   output logic              o_done
`ifdef NFU1_PERF_CNT_EN
   ,output logic [31:0]      o_stall_cycles
`endif
);

   localparam int CRD_W  = nfu_cnt_w(CREDITS);
   localparam int PIPE_D = 1 + MULT_LAT;

   if (BIT_WIDTH < 1 || Tn < 1 || MULT_LAT < 1 || CREDITS < 1) begin : g_bad_cfg
      $error("nfu1_issue_ctrl: invalid parameter set");
   end

   nfu_state_e        state_q;
   logic [CNT_W-1:0]  k_q;
   logic [CNT_W-1:0]  num_tiles_q;
   logic [ADDR_W-1:0] nbin_addr_q;
   logic [ADDR_W-1:0] sb_addr_q;
   logic [CRD_W-1:0]  credit_q;
   logic [CRD_W-1:0]  credit_d;
   logic [PIPE_D-1:0] taps;
   logic              issue;
   logic              last_tile;

   assign issue     = (state_q == RUN) && (credit_q != '0);
   assign last_tile = (k_q == num_tiles_q - CNT_W'(1));

   // Simultaneous issue and return cancel; returns beyond full are dropped.
   always_comb begin
      credit_d = credit_q;
      unique case ({issue, i_credit_ret})
         2'b10:   credit_d = credit_q - CRD_W'(1);
         2'b01:   if (credit_q < CRD_W'(CREDITS)) credit_d = credit_q + CRD_W'(1);
         default: credit_d = credit_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         k_q         <= '0;
         num_tiles_q <= '0;
         nbin_addr_q <= '0;
         sb_addr_q   <= '0;
         credit_q    <= CRD_W'(CREDITS);
      end else begin
         credit_q <= credit_d;
         unique case (state_q)
            IDLE: begin
               if (i_start) begin
                  num_tiles_q <= i_num_tiles;
                  nbin_addr_q <= i_nbin_base;
                  sb_addr_q   <= i_sb_base;
                  k_q         <= '0;
                  state_q     <= (i_num_tiles == '0) ? DONE : RUN;
               end
            end
            RUN: begin
               if (issue) begin
                  k_q         <= k_q + CNT_W'(1);
                  nbin_addr_q <= nbin_addr_q + ADDR_W'(1);
                  sb_addr_q   <= sb_addr_q + ADDR_W'(1);
                  if (last_tile) state_q <= DRAIN;
               end
            end
            DRAIN: begin
               if (taps == '0) state_q <= DONE;
            end
            DONE: begin
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   nfu_valid_pipe #(
      .DEPTH (PIPE_D)
   ) u_valid_pipe (
      .clk    (clk),
      .rst_n  (rst_n),
      .din_i  (issue),
      .taps_o (taps)
   );

`ifdef NFU1_PERF_CNT_EN
   logic [31:0] stall_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         stall_q <= '0;
      end else if (state_q == IDLE && i_start) begin
         stall_q <= '0;
      end else if (state_q == RUN && credit_q == '0 && stall_q != '1) begin
         stall_q <= stall_q + 32'd1;
      end
   end

   assign o_stall_cycles = stall_q;
`endif

   assign o_nbin_rd_en = issue;
   assign o_sb_rd_en   = issue;
   assign o_nbin_addr  = issue ? nbin_addr_q : '0;
   assign o_sb_addr    = issue ? sb_addr_q : '0;
   assign o_nfu1_valid = taps[0];
   assign o_nfu2_valid = taps[PIPE_D-1];
   assign o_busy       = (state_q == RUN) || (state_q == DRAIN);
   assign o_done       = (state_q == DONE);

endmodule

// File: tb/tb_nfu1_issue_ctrl.sv
// Directed-vector bench for nfu1_issue_ctrl; stall-counter checks need NFU1_PERF_CNT_EN.
module tb_nfu1_issue_ctrl;

   localparam int CNT_W  = 16;
   localparam int ADDR_W = 10;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              i_start;
   logic [CNT_W-1:0]  i_num_tiles;
   logic [ADDR_W-1:0] i_nbin_base;
   logic [ADDR_W-1:0] i_sb_base;
   logic              i_credit_ret;
   logic              o_nbin_rd_en;
   logic [ADDR_W-1:0] o_nbin_addr;
   logic              o_sb_rd_en;
   logic [ADDR_W-1:0] o_sb_addr;
   logic              o_nfu1_valid;
   logic              o_nfu2_valid;
   logic              o_busy;
   logic              o_done;
`ifdef NFU1_PERF_CNT_EN
   logic [31:0]       o_stall_cycles;
`endif

   int vec_cnt = 0;
   int err_cnt = 0;

   nfu1_issue_ctrl dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .i_start      (i_start),
      .i_num_tiles  (i_num_tiles),
      .i_nbin_base  (i_nbin_base),
      .i_sb_base    (i_sb_base),
      .o_nbin_rd_en (o_nbin_rd_en),
      .o_nbin_addr  (o_nbin_addr),
      .o_sb_rd_en   (o_sb_rd_en),
      .o_sb_addr    (o_sb_addr),
      .o_nfu1_valid (o_nfu1_valid),
      .o_nfu2_valid (o_nfu2_valid),
      .i_credit_ret (i_credit_ret),
      .o_busy       (o_busy),
      .o_done       (o_done)
`ifdef NFU1_PERF_CNT_EN
      ,.o_stall_cycles (o_stall_cycles)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vec_cnt++;
      if (obs !== exp) begin
         err_cnt++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic start_job(input int n, input int nb, input int sb);
      i_start     = 1'b1;
      i_num_tiles = CNT_W'(n);
      i_nbin_base = ADDR_W'(nb);
      i_sb_base   = ADDR_W'(sb);
      cyc();
      i_start = 1'b0;
   endtask

   task automatic ret_credits(input int n);
      i_credit_ret = 1'b1;
      repeat (n) cyc();
      i_credit_ret = 1'b0;
   endtask

   task automatic count_done(input int window, output int pulses);
      pulses = 0;
      for (int i = 0; i < window; i++) begin
         if (o_done) pulses++;
         cyc();
      end
   endtask

   initial begin
      int pulses;
      int issues;
      int tile;
      bit exp_rd;

      rst_n        = 1'b0;
      i_start      = 1'b0;
      i_num_tiles  = '0;
      i_nbin_base  = '0;
      i_sb_base    = '0;
      i_credit_ret = 1'b0;
      repeat (3) cyc();

      // Reset state
      chk("rst_rd", 32'(o_nbin_rd_en), 32'd0);
      chk("rst_addr", 32'(o_nbin_addr), 32'd0);
      chk("rst_busy", 32'(o_busy), 32'd0);
      chk("rst_done", 32'(o_done), 32'd0);
      chk("rst_nfu2", 32'(o_nfu2_valid), 32'd0);
      rst_n = 1'b1;
      cyc();
      $display("reset: vectors=%0d miscompares=%0d", vec_cnt, err_cnt);

      // Five tiles, plenty of credit; a stray start mid-job must be ignored
      start_job(5, 'h10, 'h20);
      for (int c = 1; c <= 12; c++) begin
         exp_rd = (c >= 1 && c <= 5);
         chk($sformatf("t1_rd_c%0d", c), 32'(o_nbin_rd_en), 32'(exp_rd));
         chk($sformatf("t1_sbrd_c%0d", c), 32'(o_sb_rd_en), 32'(exp_rd));
         chk($sformatf("t1_nba_c%0d", c), 32'(o_nbin_addr), exp_rd ? 32'('h10 + c - 1) : 32'd0);
         chk($sformatf("t1_sba_c%0d", c), 32'(o_sb_addr), exp_rd ? 32'('h20 + c - 1) : 32'd0);
         chk($sformatf("t1_nfu1_c%0d", c), 32'(o_nfu1_valid), 32'(c >= 2 && c <= 6));
         chk($sformatf("t1_nfu2_c%0d", c), 32'(o_nfu2_valid), 32'(c >= 5 && c <= 9));
         chk($sformatf("t1_busy_c%0d", c), 32'(o_busy), 32'(c >= 1 && c <= 10));
         chk($sformatf("t1_done_c%0d", c), 32'(o_done), 32'(c == 11));
         i_start     = (c == 3);
         i_num_tiles = '0;
         cyc();
      end
      i_start = 1'b0;
      $display("job5: vectors=%0d miscompares=%0d", vec_cnt, err_cnt);
      ret_credits(5);

      // Zero-tile job completes immediately with no reads
      start_job(0, 'h55, 'h66);
      chk("t2_done_c1", 32'(o_done), 32'd1);
      chk("t2_rd_c1", 32'(o_nbin_rd_en), 32'd0);
      chk("t2_busy_c1", 32'(o_busy), 32'd0);
      cyc();
      chk("t2_done_c2", 32'(o_done), 32'd0);
      chk("t2_rd_c2", 32'(o_nbin_rd_en), 32'd0);
      $display("job0: vectors=%0d miscompares=%0d", vec_cnt, err_cnt);

      // Address wrap at the top of the buffer
      start_job(4, 'h3FE, 'h001);
      for (int c = 1; c <= 4; c++) begin
         chk($sformatf("t3_rd_c%0d", c), 32'(o_nbin_rd_en), 32'd1);
         chk($sformatf("t3_nba_c%0d", c), 32'(o_nbin_addr), 32'(('h3FE + c - 1) & 'h3FF));
         chk($sformatf("t3_sba_c%0d", c), 32'(o_sb_addr), 32'('h001 + c - 1));
         cyc();
      end
      count_done(12, pulses);
      chk("t3_done_cnt", 32'(pulses), 32'd1);
      $display("wrap: vectors=%0d miscompares=%0d", vec_cnt, err_cnt);
      ret_credits(4);

      // Twelve tiles: credit exhaustion, single returns, issue+return at count 1
      start_job(12, 'h40, 'h80);
      issues = 0;
      tile   = 0;
      for (int c = 1; c <= 20; c++) begin
         exp_rd = (c <= 8) || (c == 13) || (c == 17) || (c == 18) || (c == 20);
         chk($sformatf("t4_rd_c%0d", c), 32'(o_nbin_rd_en), 32'(exp_rd));
         chk($sformatf("t4_busy_c%0d", c), 32'(o_busy), 32'd1);
         if (exp_rd) begin
            chk($sformatf("t4_nba_c%0d", c), 32'(o_nbin_addr), 32'('h40 + tile));
            tile++;
         end
         if (c <= 12 && o_nbin_rd_en) issues++;
         if (c == 12) chk("t4_issues_before_ret", 32'(issues), 32'd8);
`ifdef NFU1_PERF_CNT_EN
         if (c == 16) chk("t4_stall_cnt", o_stall_cycles, 32'd6);
`endif
         i_credit_ret = (c == 12) || (c == 16) || (c == 17) || (c == 19);
         cyc();
      end
      i_credit_ret = 1'b0;
      count_done(10, pulses);
      chk("t4_done_cnt", 32'(pulses), 32'd1);
      $display("credit: vectors=%0d miscompares=%0d", vec_cnt, err_cnt);
      ret_credits(8);
      ret_credits(3);

      // Saturated credit still allows only 8 issues; then reset mid-job
      start_job(10, 'h80, 'h90);
      issues = 0;
      for (int c = 1; c <= 10; c++) begin
`ifdef NFU1_PERF_CNT_EN
         if (c == 1) chk("t5_stall_clr", o_stall_cycles, 32'd0);
`endif
         if (o_nbin_rd_en) issues++;
         if (c < 10) cyc();
      end
      chk("t5_issues_sat", 32'(issues), 32'd8);
      chk("t5_nfu2_pre_rst", 32'(o_nfu2_valid), 32'd1);
      rst_n = 1'b0;
      cyc();
      chk("t5_rst_busy", 32'(o_busy), 32'd0);
      chk("t5_rst_rd", 32'(o_nbin_rd_en), 32'd0);
      chk("t5_rst_addr", 32'(o_sb_addr), 32'd0);
      chk("t5_rst_nfu1", 32'(o_nfu1_valid), 32'd0);
      chk("t5_rst_nfu2", 32'(o_nfu2_valid), 32'd0);
      chk("t5_rst_done", 32'(o_done), 32'd0);
      rst_n = 1'b1;
      count_done(8, pulses);
      chk("t5_no_done", 32'(pulses), 32'd0);
      start_job(3, 'h100, 'h200);
      for (int c = 1; c <= 3; c++) begin
         chk($sformatf("t5_rd_c%0d", c), 32'(o_nbin_rd_en), 32'd1);
         chk($sformatf("t5_nba_c%0d", c), 32'(o_nbin_addr), 32'('h100 + c - 1));
         chk($sformatf("t5_sba_c%0d", c), 32'(o_sb_addr), 32'('h200 + c - 1));
         cyc();
      end
      chk("t5_rd_c4", 32'(o_nbin_rd_en), 32'd0);
      count_done(12, pulses);
      chk("t5_done_cnt", 32'(pulses), 32'd1);
      $display("reset_mid: vectors=%0d miscompares=%0d", vec_cnt, err_cnt);

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule
